// File: rtl/serial_add_pkg.sv
// Shared types and sizing helpers for the bit-serial signed adder.
package serial_add_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Bit counter must reach W-1; keep at least one bit for W = 2.
    function automatic int cnt_width(input int w);
        return (w <= 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/serial_signed_adder_fa_bit.sv
// Combinational 1-bit full adder built from XOR/AND/OR gates.
module fa_bit (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    logic p;

    assign p    = a ^ b;
    assign s    = p ^ cin;
    assign cout = (a & b) | (cin & p);

endmodule

// File: rtl/serial_signed_adder.sv
// Bit-serial two's-complement adder, LSB first, with signed overflow flag.
// Optional saturation of overflowed results: define SERIAL_ADD_SATURATE_EN.
//
//   state | meaning
//   IDLE  | waiting for operands, in_ready high
//   SHIFT | one full-adder step per clock, W steps total
//   DONE  | result held, out_valid high until out_ready
module serial_signed_adder
    import serial_add_pkg::*;
#(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] sum,
    output logic         overflow
);

    localparam int            CW   = cnt_width(W);
    localparam logic [CW-1:0] LAST = CW'(W - 1);

    state_t         state;
    logic [W-1:0]   a_sh;
    logic [W-1:0]   b_sh;
    logic [W-1:0]   sum_r;
    logic           carry;
    logic [CW-1:0]  cnt;
    logic           fa_s;
    logic           fa_c;
    logic [W-1:0]   sum_shift;
    logic [W-1:0]   sum_fin;
    logic           msb_ovf;

    fa_bit u_fa (
        .a    (a_sh[0]),
        .b    (b_sh[0]),
        .cin  (carry),
        .s    (fa_s),
        .cout (fa_c)
    );

    assign sum_shift = {fa_s, sum_r[W-1:1]};
    assign msb_ovf   = carry ^ fa_c;

`ifdef SERIAL_ADD_SATURATE_EN
    // On overflow both operands share a sign; a_sh[0] is that sign at the MSB step.
    logic [W-1:0] sat_val;
    assign sat_val = a_sh[0] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    assign sum_fin = msb_ovf ? sat_val : sum_shift;
`else
    assign sum_fin = sum_shift;
`endif

    assign in_ready  = (state == IDLE) && rst;
    assign sum       = sum_r;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            a_sh      <= '0;
            b_sh      <= '0;
            sum_r     <= '0;
            carry     <= 1'b0;
            cnt       <= '0;
            out_valid <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_sh  <= a;
                        b_sh  <= b;
                        carry <= 1'b0;
                        cnt   <= '0;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    a_sh  <= a_sh >> 1;
                    b_sh  <= b_sh >> 1;
                    cnt   <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        // Final carry-out only feeds the overflow rule.
                        sum_r     <= sum_fin;
                        overflow  <= msb_ovf;
                        carry     <= 1'b0;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        sum_r <= sum_shift;
                        carry <= fa_c;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
